cpc_rom_loader: RTL and testbench

- Parametrised boot-ROM loader. Takes the OSD download byte stream (index 0) and writes it into SDRAM ROM pages through a runtime-programmable slot map.
- Replaces the fixed 4-slot/2-model decode in the top level. Supports SLOTS 16 KB slots per model bank and BANKS banks.
- Decouples download rate from SDRAM acceptance with a small FIFO and a req/ack write handshake.

---
 rtl/cpc_rom_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_cpc_rom_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_rom_loader.sv
// cpc_rom_loader
//   Boot-ROM loader. Takes the OSD download byte stream and writes it into
//   SDRAM ROM pages through a runtime-programmable slot map
//   (SLOTS 16 KB slots per bank, BANKS model banks).
//   A small byte FIFO decouples the download rate from SDRAM acceptance.
//
// Optional feature macro: CPC_ROM_LOADER_CSUM_EN
//   When defined, adds a per-entry 16-bit additive checksum of the bytes
//   acknowledged by SDRAM, which can be read back through csum_sel/csum.
//
// Ports:
//   clk_sys, reset         system clock, synchronous active-high reset
//   dl_active/index/wr/addr/data   OSD download stream
//   map_we/slot/page       slot map write port
//   mem_req/addr/bank/din  SDRAM write request, mem_ack accepts it
//   busy                   loader active or FIFO holds data
//   done                   one-cycle pulse when a download has drained
//   overflow               sticky: byte lost to a full FIFO
//   dropped                saturating count of out-of-range bytes
//   slot_loaded            per-entry sticky "written at least once"
//   csum_sel, csum         (optional) checksum read port, 1-cycle latency
module cpc_rom_loader #(
  parameter int SLOTS      = 8,
  parameter int BANKS      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_INDEX  = 0
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic                             dl_active,
  input  logic [7:0]                       dl_index,
  input  logic                             dl_wr,
  input  logic [24:0]                      dl_addr,
  input  logic [7:0]                       dl_data,
  input  logic                             map_we,
  input  logic [$clog2(SLOTS*BANKS)-1:0]   map_slot,
  input  logic [8:0]                       map_page,
  output logic                             mem_req,
  output logic [22:0]                      mem_addr,
  output logic [1:0]                       mem_bank,
  output logic [7:0]                       mem_din,
  input  logic                             mem_ack,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow,
  output logic [15:0]                      dropped,
`ifdef CPC_ROM_LOADER_CSUM_EN
  input  logic [$clog2(SLOTS*BANKS)-1:0]   csum_sel,
  output logic [15:0]                      csum,
`endif
  output logic [SLOTS*BANKS-1:0]           slot_loaded
);

  localparam int ENTRIES = SLOTS * BANKS;
  localparam int EW      = $clog2(ENTRIES);
  localparam int SW      = $clog2(SLOTS);
  localparam int PW      = $clog2(FIFO_DEPTH);

  localparam logic [10:0] ENTRIES_S = 11'(ENTRIES);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [1:0]    bank;
    logic [EW-1:0] entry;
    logic [22:0]   addr;
    logic [7:0]    data;
  } fifo_entry_t;

  // Power-on page for a map entry; the pattern repeats in every bank.
  function automatic logic [8:0] default_page(input int unsigned idx);
    int unsigned k;
    k = idx % SLOTS;
    case (k)
      0:       return 9'h000;
      1:       return 9'h100;
      2:       return 9'h107;
      3:       return 9'h1FF;
      default: return 9'(32'h100 + k - 32'd3);
    endcase
  endfunction

  logic [1:0]    state;
  logic          act_q;
  logic [8:0]    map_tbl [ENTRIES];

  fifo_entry_t   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [EW-1:0] req_entry;

  logic          act, rise, start, running;
  logic          push_en, in_range, push, pop, ovf_ev, drop_ev;
  logic          empty, full;
  logic [10:0]   s;
  fifo_entry_t   entry_in;

  assign act      = dl_active && (dl_index == 8'(ROM_INDEX));
  assign rise     = act && !act_q;
  assign start    = (state == S_IDLE) && rise;
  assign running  = (state == S_LOAD) || (state == S_DRAIN);
  assign empty    = (count == '0);
  assign full     = (count == FIFO_FULL);

  assign s        = dl_addr[24:14];
  assign in_range = (s < ENTRIES_S);

  assign push_en  = act && (running || start);
  assign push     = push_en && dl_wr && in_range && !full;
  assign ovf_ev   = push_en && dl_wr && in_range && full;
  assign drop_ev  = push_en && dl_wr && !in_range;
  // A new request is only issued once the previous one has been dropped,
  // which gives the 2-cycle minimum spacing after an ack.
  assign pop      = running && !mem_req && !empty;

  // Address translation happens here, at FIFO entry, so later map writes
  // never affect bytes already queued.
  always_comb begin
    entry_in       = '0;
    entry_in.bank  = 2'(s >> SW);
    entry_in.entry = s[EW-1:0];
    entry_in.addr  = {map_tbl[s[EW-1:0]], dl_addr[13:0]};
    entry_in.data  = dl_data;
  end

  assign busy = (state != S_IDLE) || !empty;
  assign done = (state == S_DONE);

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= entry_in;
  end

`ifdef CPC_ROM_LOADER_CSUM_EN
  logic [15:0] sums [ENTRIES];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) sums[EW'(i)] <= '0;
      csum <= '0;
    end else begin
      if (start) begin
        for (int unsigned i = 0; i < ENTRIES; i++) sums[EW'(i)] <= '0;
      end else if (mem_req && mem_ack) begin
        sums[req_entry] <= sums[req_entry] + {8'h00, mem_din};
      end
      csum <= sums[csum_sel];
    end
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      act_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_bank    <= '0;
      mem_din     <= '0;
      req_entry   <= '0;
      overflow    <= 1'b0;
      dropped     <= '0;
      slot_loaded <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) map_tbl[EW'(i)] <= default_page(i);
    end else begin
      act_q <= act;

      if (map_we && (32'(map_slot) < ENTRIES)) map_tbl[map_slot] <= map_page;

      // FIFO pointers and occupancy
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Request register and handshake; an ack without a request is ignored.
      if (pop) begin
        mem_req   <= 1'b1;
        mem_addr  <= fifo_mem[rd_ptr].addr;
        mem_bank  <= fifo_mem[rd_ptr].bank;
        mem_din   <= fifo_mem[rd_ptr].data;
        req_entry <= fifo_mem[rd_ptr].entry;
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end

      // Status: the start-of-download clear still counts same-cycle events.
      if (start) begin
        slot_loaded <= '0;
        overflow    <= ovf_ev;
        dropped     <= drop_ev ? 16'd1 : 16'd0;
      end else begin
        if (mem_req && mem_ack) slot_loaded[req_entry] <= 1'b1;
        if (ovf_ev) overflow <= 1'b1;
        if (drop_ev && (dropped != 16'hFFFF)) dropped <= dropped + 16'd1;
      end

      case (state)
        S_IDLE:  if (rise) state <= S_LOAD;
        S_LOAD:  if (!act) state <= S_DRAIN;
        S_DRAIN: begin
          if (act)                   state <= S_LOAD;
          else if (empty && !mem_req) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_rom_loader.sv
// tb_cpc_rom_loader
//   Directed self-checking bench for cpc_rom_loader with default parameters
//   (SLOTS=8, BANKS=2, FIFO_DEPTH=4, ROM_INDEX=0).
module tb_cpc_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        map_we;
  logic [3:0]  map_slot;
  logic [8:0]  map_page;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] dropped;
  logic [15:0] slot_loaded;
`ifdef CPC_ROM_LOADER_CSUM_EN
  logic [3:0]  csum_sel;
  logic [15:0] csum;
`endif

  int checks   = 0;
  int failures = 0;

  cpc_rom_loader #(
    .SLOTS(8), .BANKS(2), .FIFO_DEPTH(4), .ROM_INDEX(0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_index(dl_index), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .map_we(map_we), .map_slot(map_slot), .map_page(map_page),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .busy(busy), .done(done), .overflow(overflow), .dropped(dropped),
`ifdef CPC_ROM_LOADER_CSUM_EN
    .csum_sel(csum_sel), .csum(csum),
`endif
    .slot_loaded(slot_loaded)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_dl();
    dl_active = 1'b1;
    dl_index  = 8'd0;
    tick();
  endtask

  task automatic stop_dl();
    dl_active = 1'b0;
    tick();
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (mem_req === 1'b1) break;
      tick();
    end
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
  endtask

  task automatic ack_next(input string tag, input logic [22:0] ea,
                          input logic [1:0] eb, input logic [7:0] ed);
    wait_req(tag);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
    chk({tag, "_bank"}, 32'(mem_bank), 32'(eb));
    chk({tag, "_din"},  32'(mem_din),  32'(ed));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_index = 8'd0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; map_we = 1'b0; map_slot = '0; map_page = '0;
    mem_ack = 1'b0;
`ifdef CPC_ROM_LOADER_CSUM_EN
    csum_sel = '0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_req",      32'(mem_req),     32'd0);
    chk("rst_addr",     32'(mem_addr),    32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_done",     32'(done),        32'd0);
    chk("rst_ovf",      32'(overflow),    32'd0);
    chk("rst_dropped",  32'(dropped),     32'd0);
    chk("rst_loaded",   32'(slot_loaded), 32'd0);

    // Wrong download index: ignored entirely
    dl_active = 1'b1; dl_index = 8'd1;
    tick();
    send(25'h0_8005, 8'hEE);
    tick(); tick();
    chk("idx_req",  32'(mem_req), 32'd0);
    chk("idx_busy", 32'(busy),    32'd0);
    dl_active = 1'b0; dl_index = 8'd0;
    tick(); tick();

    // Default map translation and bank select
    start_dl();
    chk("start_busy", 32'(busy), 32'd1);
    send(25'h0_8005, 8'hA5);
    ack_next("slot2", 23'h41C005, 2'd0, 8'hA5);
    send(25'h1_4000, 8'h5A);
    ack_next("slot5", 23'h408000, 2'd0, 8'h5A);
    send(25'h2_0000, 8'h11);
    ack_next("slot8", 23'h000000, 2'd1, 8'h11);
    chk("loaded_a", 32'(slot_loaded), 32'h0000_0124);

    // Runtime map write
    map_we = 1'b1; map_slot = 4'd3; map_page = 9'h0AB;
    tick();
    map_we = 1'b0;
    send(25'h0_C010, 8'h3C);
    ack_next("map3", 23'h2AC010, 2'd0, 8'h3C);

    // Completion with two bytes queued at download end
    send(25'h0_0001, 8'hFF);
    send(25'h0_0002, 8'h02);
    stop_dl();
    chk("drain_busy0", 32'(busy), 32'd1);
    ack_next("drain1", 23'h000001, 2'd0, 8'hFF);
    chk("drain_busy1", 32'(busy), 32'd1);
    chk("drain_done1", 32'(done), 32'd0);
    ack_next("drain2", 23'h000002, 2'd0, 8'h02);
    chk("drain_busy2", 32'(busy), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
    chk("done_pulses", 32'(n),           32'd1);
    chk("done_busy",   32'(busy),        32'd0);
    chk("loaded_b",    32'(slot_loaded), 32'h0000_012D);
`ifdef CPC_ROM_LOADER_CSUM_EN
    csum_sel = 4'd0;
    tick();
    chk("csum0", 32'(csum), 32'h0000_0101);
`endif

    // Out-of-range bytes (s = 16)
    start_dl();
    chk("oor_loaded_clr", 32'(slot_loaded), 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      send(25'h4_0000 + 25'(i), 8'h99);
      if (mem_req === 1'b1) n++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req === 1'b1) n++;
    end
    chk("oor_reqs",    32'(n),       32'd0);
    chk("oor_dropped", 32'(dropped), 32'd3);
    stop_dl();
    repeat (4) tick();
    chk("oor_idle_dropped", 32'(dropped), 32'd3);
    start_dl();
    chk("oor_clear", 32'(dropped), 32'd0);

    // Back-pressure: 6 bytes, acks withheld
    for (int i = 0; i < 6; i++) send(25'h0_4000 + 25'(i), 8'h30 + 8'(i));
    chk("bp_ovf",  32'(overflow), 32'd1);
    chk("bp_req",  32'(mem_req),  32'd1);
    repeat (20) tick();
    chk("bp_hold_req",  32'(mem_req),  32'd1);
    chk("bp_hold_addr", 32'(mem_addr), 32'h0040_0000);
    chk("bp_hold_din",  32'(mem_din),  32'h30);
    for (int i = 0; i < 5; i++)
      ack_next($sformatf("bp%0d", i), 23'h400000 + 23'(i), 2'd1 - 2'd1, 8'h30 + 8'(i));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req === 1'b1) n++;
    end
    chk("bp_no_sixth", 32'(n),        32'd0);
    chk("bp_ovf_stky", 32'(overflow), 32'd1);

    // Reset with a request outstanding and a byte queued
    map_we = 1'b1; map_slot = 4'd0; map_page = 9'h055;
    tick();
    map_we = 1'b0;
    send(25'h0_0003, 8'h77);
    wait_req("mr");
    chk("mr_addr", 32'(mem_addr), 32'h0015_4003);
    send(25'h0_0004, 8'h78);
    reset = 1'b1; dl_active = 1'b0;
    tick();
    chk("mr_req",  32'(mem_req),  32'd0);
    chk("mr_busy", 32'(busy),     32'd0);
    chk("mr_ovf",  32'(overflow), 32'd0);
    reset = 1'b0;
    tick();
    start_dl();
    send(25'h0_0003, 8'h79);
    ack_next("mr_map", 23'h000003, 2'd0, 8'h79);
    stop_dl();
    repeat (4) tick();
    chk("end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
